// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, FSM state and slot record for sprite_line_engine
package sprite_pkg;

  localparam int DEF_SPRITE_NUM = 64;
  localparam int DEF_SLOT_NUM   = 8;
  localparam int DEF_POS_BIT    = 10;
  localparam int DEF_SPRITE_W   = 16;
  localparam int DEF_SPRITE_H   = 16;
  localparam int DEF_PIX_BIT    = 2;
  localparam int DEF_TILE_BIT   = 8;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int OAM_AW  = clog2_min1(DEF_SPRITE_NUM);
  localparam int SLOT_AW = clog2_min1(DEF_SLOT_NUM);
  localparam int ROW_AW  = clog2_min1(DEF_SPRITE_H);
  localparam int COL_AW  = clog2_min1(DEF_SPRITE_W);

  localparam int ATTR_X_LSB    = 0;
  localparam int ATTR_Y_LSB    = 10;
  localparam int ATTR_TILE_LSB = 20;
  localparam int ATTR_HFLIP    = 28;
  localparam int ATTR_VFLIP    = 29;
  localparam int ATTR_EN       = 31;

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

  typedef struct packed {
    logic                              valid;
    logic [DEF_POS_BIT-1:0]            x;
    logic                              hflip;
    logic [DEF_SPRITE_W*DEF_PIX_BIT-1:0] row_data;
  } slot_t;

endpackage

// File: rtl/sprite_slot_prio.sv
// rtl/sprite_slot_prio.sv - per-slot hit/opacity test and lowest-index priority encoder
// Horizontal mirroring is compiled in only when SPRITE_HFLIP_EN is defined.
module sprite_slot_prio
  import sprite_pkg::*;
#(
  parameter int SLOT_NUM = DEF_SLOT_NUM,
  parameter int SW       = SLOT_AW
) (
  input  slot_t                  slots [SLOT_NUM],
  input  logic [DEF_POS_BIT-1:0] pos_x,
  output logic                   hit,
  output logic [DEF_PIX_BIT-1:0] idx,
  output logic [SW-1:0]          slot
);

  localparam int PW = DEF_POS_BIT;

  always_comb begin
    logic [PW-1:0]          dx;
    logic [COL_AW-1:0]      col;
    logic [DEF_PIX_BIT-1:0] pix;
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    dx   = '0;
    col  = '0;
    pix  = '0;
    // Walk downwards so the lowest-numbered opaque slot is the last to assign.
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      dx = pos_x - slots[i].x;
`ifdef SPRITE_HFLIP_EN
      col = slots[i].hflip ? (COL_AW'(DEF_SPRITE_W - 1) - dx[COL_AW-1:0]) : dx[COL_AW-1:0];
`else
      col = dx[COL_AW-1:0];
`endif
      pix = slots[i].row_data[col*DEF_PIX_BIT +: DEF_PIX_BIT];
      if (slots[i].valid && (dx < PW'(DEF_SPRITE_W)) && (pix != '0)) begin
        hit  = 1'b1;
        idx  = pix;
        slot = SW'(i);
      end
    end
  end

`ifndef SPRITE_HFLIP_EN
  logic [SLOT_NUM-1:0] unused_hflip;
  for (genvar g = 0; g < SLOT_NUM; g++) begin : g_unused_hflip
    assign unused_hflip[g] = slots[g].hflip;
  end
`endif

endmodule

// File: rtl/sprite_line_engine.sv
// rtl/sprite_line_engine.sv - per-scanline sprite selection, tile-row fetch and pixel priority
// SPRITE_HFLIP_EN enables horizontal mirroring in the display path.
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter int SPRITE_NUM = DEF_SPRITE_NUM,
  parameter int SLOT_NUM   = DEF_SLOT_NUM,
  parameter int POS_BIT    = DEF_POS_BIT,
  parameter int SPRITE_W   = DEF_SPRITE_W,
  parameter int SPRITE_H   = DEF_SPRITE_H,
  parameter int PIX_BIT    = DEF_PIX_BIT,
  parameter int TILE_BIT   = DEF_TILE_BIT,
  localparam int AW = clog2_min1(SPRITE_NUM),
  localparam int SW = clog2_min1(SLOT_NUM),
  localparam int RW = clog2_min1(SPRITE_H),
  localparam int CW = $clog2(SLOT_NUM + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         line_start,
  input  logic [POS_BIT-1:0]           next_line_y,
  input  logic                         game_window,
  input  logic [POS_BIT-1:0]           vga_pos_x,
  output logic [AW-1:0]                oam_addr,
  input  logic [31:0]                  oam_rdata,
  output logic [TILE_BIT+RW-1:0]       rom_addr,
  input  logic [SPRITE_W*PIX_BIT-1:0]  rom_rdata,
  output logic [PIX_BIT-1:0]           pix_idx,
  output logic [SW-1:0]                pix_slot,
  output logic                         pix_hit,
  output logic                         overflow,
  output logic                         late_err
);

  state_t               state;
  logic [POS_BIT-1:0]   line_y;
  logic                 rd_pend;
  logic                 scan_last;
  logic [CW-1:0]        used;
  logic [CW-1:0]        fi;
  logic                 c_vld;
  logic [SW-1:0]        c_idx;
  logic                 work_ovf;
  slot_t                work [SLOT_NUM];
  slot_t                act  [SLOT_NUM];
  logic [TILE_BIT-1:0]  f_tile [SLOT_NUM];
  logic [RW-1:0]        f_row  [SLOT_NUM];

  logic [POS_BIT-1:0]   dy;
  logic                 in_range;
  logic [RW-1:0]        row_sel;
  logic                 full;
  logic                 take;
  logic                 late;
  logic [SW-1:0]        used_idx;
  logic [SW-1:0]        fi_idx;
  logic                 unused_rsvd;

  assign unused_rsvd = oam_rdata[30];

  always_comb begin
    dy       = line_y - oam_rdata[ATTR_Y_LSB +: POS_BIT];
    in_range = oam_rdata[ATTR_EN] && (dy < POS_BIT'(SPRITE_H));
    row_sel  = oam_rdata[ATTR_VFLIP] ? (RW'(SPRITE_H - 1) - dy[RW-1:0]) : dy[RW-1:0];
    full     = (used == CW'(SLOT_NUM));
    take     = rd_pend && in_range && !full;
    late     = (state == SCAN) || (state == FETCH);
    used_idx = full ? '0 : SW'(used);
    fi_idx   = (fi < CW'(SLOT_NUM)) ? SW'(fi) : '0;
  end

  assign rom_addr = {f_tile[fi_idx], f_row[fi_idx]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      line_y    <= '0;
      oam_addr  <= '0;
      rd_pend   <= 1'b0;
      scan_last <= 1'b0;
      used      <= '0;
      fi        <= '0;
      c_vld     <= 1'b0;
      c_idx     <= '0;
      work_ovf  <= 1'b0;
      overflow  <= 1'b0;
      late_err  <= 1'b0;
      for (int i = 0; i < SLOT_NUM; i++) begin
        work[i]   <= '0;
        act[i]    <= '0;
        f_tile[i] <= '0;
        f_row[i]  <= '0;
      end
    end else if (line_start) begin
      // An unfinished evaluation is discarded rather than shown half-built.
      late_err <= late_err | late;
      overflow <= late ? 1'b0 : work_ovf;
      for (int i = 0; i < SLOT_NUM; i++) begin
        act[i]  <= late ? slot_t'('0) : work[i];
        work[i] <= '0;
      end
      work_ovf  <= 1'b0;
      line_y    <= next_line_y;
      oam_addr  <= '0;
      rd_pend   <= 1'b0;
      scan_last <= 1'b0;
      used      <= '0;
      fi        <= '0;
      c_vld     <= 1'b0;
      state     <= SCAN;
    end else begin
      case (state)
        SCAN: begin
          if (rd_pend && in_range && full) begin
            work_ovf <= 1'b1;
          end
          if (take) begin
            work[used_idx].x     <= oam_rdata[ATTR_X_LSB +: POS_BIT];
            work[used_idx].hflip <= oam_rdata[ATTR_HFLIP];
            f_tile[used_idx]     <= oam_rdata[ATTR_TILE_LSB +: TILE_BIT];
            f_row[used_idx]      <= row_sel;
            used                 <= used + CW'(1);
          end
          if (scan_last) begin
            state <= ((used == '0) && !take) ? DONE : FETCH;
            fi    <= '0;
            c_vld <= 1'b0;
          end else begin
            rd_pend <= 1'b1;
            if (oam_addr == AW'(SPRITE_NUM - 1)) begin
              scan_last <= 1'b1;
            end else begin
              oam_addr <= oam_addr + AW'(1);
            end
          end
        end
        FETCH: begin
          c_vld <= (fi < used);
          if (fi < used) begin
            c_idx <= fi_idx;
            fi    <= fi + CW'(1);
          end
          if (c_vld) begin
            work[c_idx].row_data <= rom_rdata;
            work[c_idx].valid    <= 1'b1;
            if (CW'(c_idx) + CW'(1) == used) begin
              state <= DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic               p_hit;
  logic [PIX_BIT-1:0] p_idx;
  logic [SW-1:0]      p_slot;

  sprite_slot_prio #(
    .SLOT_NUM (SLOT_NUM),
    .SW       (SW)
  ) u_prio (
    .slots (act),
    .pos_x (vga_pos_x),
    .hit   (p_hit),
    .idx   (p_idx),
    .slot  (p_slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_hit  <= 1'b0;
      pix_idx  <= '0;
      pix_slot <= '0;
    end else if (game_window && p_hit) begin
      pix_hit  <= 1'b1;
      pix_idx  <= p_idx;
      pix_slot <= p_slot;
    end else begin
      pix_hit  <= 1'b0;
      pix_idx  <= '0;
      pix_slot <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb/tb_sprite_line_engine.sv - directed self-checking bench for sprite_line_engine
module tb_sprite_line_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  next_line_y = '0;
  logic        game_window = 1'b1;
  logic [9:0]  vga_pos_x = '0;
  logic [5:0]  oam_addr;
  logic [31:0] oam_rdata = '0;
  logic [11:0] rom_addr;
  logic [31:0] rom_rdata = '0;
  logic [1:0]  pix_idx;
  logic [2:0]  pix_slot;
  logic        pix_hit;
  logic        overflow;
  logic        late_err;

  logic [31:0] oam_mem [64];
  logic [31:0] rom_mem [4096];

  int n_cmp = 0;
  int n_bad = 0;
  bit seen;

`ifdef SPRITE_HFLIP_EN
  localparam bit HF = 1'b1;
`else
  localparam bit HF = 1'b0;
`endif

  sprite_line_engine dut (
    .clk         (clk),
    .rst         (rst),
    .line_start  (line_start),
    .next_line_y (next_line_y),
    .game_window (game_window),
    .vga_pos_x   (vga_pos_x),
    .oam_addr    (oam_addr),
    .oam_rdata   (oam_rdata),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .pix_idx     (pix_idx),
    .pix_slot    (pix_slot),
    .pix_hit     (pix_hit),
    .overflow    (overflow),
    .late_err    (late_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    oam_rdata <= oam_mem[oam_addr];
    rom_rdata <= rom_mem[rom_addr];
  end

  function automatic logic [31:0] attr(input int x, input int y, input int tile,
                                       input bit hf, input bit vf);
    logic [31:0] a;
    a        = '0;
    a[9:0]   = x[9:0];
    a[19:10] = y[9:0];
    a[27:20] = tile[7:0];
    a[28]    = hf;
    a[29]    = vf;
    a[31]    = 1'b1;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int y);
    @(negedge clk);
    next_line_y = y[9:0];
    line_start  = 1'b1;
    @(negedge clk);
    line_start  = 1'b0;
  endtask

  // One line slot: pulse, then 100 cycles (covers the 75-cycle worst case) watching rom_addr.
  task automatic line(input int y, input logic [11:0] watch, output bit hit_seen);
    hit_seen = 1'b0;
    pulse(y);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rom_addr === watch) hit_seen = 1'b1;
    end
  endtask

  task automatic probe(input string tag, input int x, input logic eh,
                       input logic [1:0] ei, input logic [2:0] es);
    @(negedge clk);
    vga_pos_x = x[9:0];
    @(negedge clk);
    chk({tag, ".hit"}, {31'd0, pix_hit}, {31'd0, eh});
    chk({tag, ".idx"}, {30'd0, pix_idx}, {30'd0, ei});
    chk({tag, ".slot"}, {29'd0, pix_slot}, {29'd0, es});
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) oam_mem[i] = '0;
  endtask

  initial begin
    clear_oam();
    for (int i = 0; i < 4096; i++) rom_mem[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst.pix_hit", {31'd0, pix_hit}, 32'd0);
    chk("rst.pix_idx", {30'd0, pix_idx}, 32'd0);
    chk("rst.pix_slot", {29'd0, pix_slot}, 32'd0);
    chk("rst.overflow", {31'd0, overflow}, 32'd0);
    chk("rst.late_err", {31'd0, late_err}, 32'd0);
    chk("rst.oam_addr", {26'd0, oam_addr}, 32'd0);
    chk("rst.rom_addr", {20'd0, rom_addr}, 32'd0);
    rst = 1'b0;

    // Single sprite: X=100 Y=50 tile 3, line 55 -> row 5
    oam_mem[0] = attr(100, 50, 3, 1'b0, 1'b0);
    rom_mem[12'h035] = 32'h0000_0004;
    line(55, 12'h035, seen);
    chk("single.rom_addr_seen", {31'd0, seen}, 32'd1);
    line(56, 12'hFFF, seen);
    probe("single.x101", 101, 1'b1, 2'd1, 3'd0);
    probe("single.x100", 100, 1'b0, 2'd0, 3'd0);
    probe("single.x116", 116, 1'b0, 2'd0, 3'd0);
    game_window = 1'b0;
    probe("single.nowin", 101, 1'b0, 2'd0, 3'd0);
    game_window = 1'b1;
    chk("single.overflow", {31'd0, overflow}, 32'd0);

    // Overflow: ten sprites at Y=0, line 3; only entries 0..7 drawn
    clear_oam();
    for (int i = 0; i < 10; i++) begin
      oam_mem[i] = attr(20 * i, 0, 10 + i, 1'b0, 1'b0);
      rom_mem[((10 + i) << 4) | 3] = 32'hFFFF_FFFF;
    end
    line(3, 12'hFFF, seen);
    line(4, 12'hFFF, seen);
    chk("ovf.overflow", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) probe($sformatf("ovf.e%0d", i), 20 * i, 1'b1, 2'd3, 3'(i));
      else       probe($sformatf("ovf.e%0d", i), 20 * i, 1'b0, 2'd0, 3'd0);
    end

    // Priority and transparency at x=200
    clear_oam();
    oam_mem[0] = attr(200, 100, 20, 1'b0, 1'b0);
    oam_mem[1] = attr(195, 100, 21, 1'b0, 1'b0);
    rom_mem[12'h140] = 32'h0000_0000;
    rom_mem[12'h150] = 32'h0000_0800;
    line(100, 12'hFFF, seen);
    line(101, 12'hFFF, seen);
    chk("prio.overflow", {31'd0, overflow}, 32'd0);
    probe("prio.transp", 200, 1'b1, 2'd2, 3'd1);
    rom_mem[12'h140] = 32'h0000_0003;
    line(100, 12'hFFF, seen);
    line(101, 12'hFFF, seen);
    probe("prio.opaque", 200, 1'b1, 2'd3, 3'd0);

    // Late line_start 20 cycles into the scan
    pulse(100);
    repeat (19) @(negedge clk);
    pulse(100);
    chk("late.err", {31'd0, late_err}, 32'd1);
    probe("late.x200", 200, 1'b0, 2'd0, 3'd0);
    probe("late.x205", 205, 1'b0, 2'd0, 3'd0);
    repeat (100) @(negedge clk);
    pulse(101);
    probe("late.recover", 200, 1'b1, 2'd3, 3'd0);
    chk("late.sticky", {31'd0, late_err}, 32'd1);

    // vflip and Y wrap: Y=1020, line 2 -> row 6, rom row 9
    clear_oam();
    oam_mem[0] = attr(0, 1020, 30, 1'b1, 1'b1);
    rom_mem[12'h1E9] = 32'h4000_0002;
    line(2, 12'h1E9, seen);
    chk("vflip.rom_addr_seen", {31'd0, seen}, 32'd1);
    line(2, 12'hFFF, seen);
    probe("vflip.x0", 0, 1'b1, HF ? 2'd1 : 2'd2, 3'd0);
    probe("vflip.x15", 15, 1'b1, HF ? 2'd2 : 2'd1, 3'd0);
    probe("vflip.x1023", 1023, 1'b0, 2'd0, 3'd0);

    // Asynchronous reset in the middle of SCAN
    pulse(2);
    repeat (3) @(negedge clk);
    probe("rstmid.before", 0, 1'b1, HF ? 2'd1 : 2'd2, 3'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.pix_hit", {31'd0, pix_hit}, 32'd0);
    chk("rstmid.pix_idx", {30'd0, pix_idx}, 32'd0);
    chk("rstmid.late_err", {31'd0, late_err}, 32'd0);
    chk("rstmid.oam_addr", {26'd0, oam_addr}, 32'd0);
    chk("rstmid.overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    probe("rstmid.act_inval", 0, 1'b0, 2'd0, 3'd0);
    line(2, 12'hFFF, seen);
    probe("rstmid.work_inval", 0, 1'b0, 2'd0, 3'd0);
    line(2, 12'hFFF, seen);
    probe("rstmid.restart", 0, 1'b1, HF ? 2'd1 : 2'd2, 3'd0);
    chk("rstmid.late_clean", {31'd0, late_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
